// File: rtl/cpu_run_controller_pkg.sv
// Shared types and default widths for the CPU run controller slice.
`default_nettype none

package cpu_run_pkg;

    localparam int DEF_DATAWIDTH   = 25;
    localparam int DEF_FIFODEPTH   = 4;
    localparam int DEF_COUNTWIDTH  = 16;
    localparam int DEF_RESETCYCLES = 2;
    localparam int DEF_TIMEOUT     = 1024;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET_CPU = 3'd1,
        RUN       = 3'd2,
        DRAIN     = 3'd3,
        DONE      = 3'd4
    } run_state_t;

endpackage

`default_nettype wire

// File: rtl/cpu_run_controller_if.sv
// CPU-side and result-sink-side signals of the run controller.
`default_nettype none

interface cpu_run_controller_if #(
    parameter int DATAWIDTH = 25
);
    logic                 cpuOutFlag;
    logic [DATAWIDTH-1:0] cpuOut;
    logic                 cpuReset;
    logic                 cpuEnable;
    logic                 outValid;
    logic [DATAWIDTH-1:0] outData;
    logic                 outReady;

    modport master (
        input  cpuOutFlag, cpuOut, outReady,
        output cpuReset, cpuEnable, outValid, outData
    );

    modport slave (
        output cpuOutFlag, cpuOut, outReady,
        input  cpuReset, cpuEnable, outValid, outData
    );
endinterface

`default_nettype wire

// File: rtl/cpu_run_controller_fifo.sv
// run_out_fifo: power-of-two synchronous FIFO with flush and occupancy output.
`default_nettype none

module run_out_fifo #(
    parameter int DATAWIDTH = 25,
    parameter int DEPTH     = 4
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    input  wire logic                   flush,
    input  wire logic                   push,
    input  wire logic [DATAWIDTH-1:0]   push_data,
    input  wire logic                   pop,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic [DATAWIDTH-1:0]        head
);
    localparam int AW = $clog2(DEPTH);

    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic                 wr_en, rd_en;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem_q[rd_ptr_q];
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (wr_en && !flush) mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_run_controller.sv
// Sequences one CPU test run and buffers its flagged output words.
// Optional watchdog enabled by defining CPU_RUN_WATCHDOG_EN.
`default_nettype none

module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int DATAWIDTH   = DEF_DATAWIDTH,
    parameter int FIFODEPTH   = DEF_FIFODEPTH,
    parameter int COUNTWIDTH  = DEF_COUNTWIDTH,
    parameter int RESETCYCLES = DEF_RESETCYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  start,
    input  wire logic [COUNTWIDTH-1:0] outCount,
    cpu_run_controller_if.master       bus,
    output logic                       busy,
    output logic                       done,
    output logic [COUNTWIDTH-1:0]      captured,
    output logic                       timedOut
);
    localparam int RCW = $clog2(RESETCYCLES + 1);

    if (FIFODEPTH < 2 || (FIFODEPTH & (FIFODEPTH - 1)) != 0 || RESETCYCLES < 1 || TIMEOUT < 1)
    begin : g_param_check
        $error("cpu_run_controller: illegal parameter set");
    end

    run_state_t                state_q, state_d;
    logic [COUNTWIDTH-1:0]     count_q, count_d;
    logic [COUNTWIDTH-1:0]     captured_q, captured_d;
    logic [RCW-1:0]            rcnt_q, rcnt_d;
    logic                      cpu_reset, cpu_enable;
    logic                      fifo_flush, fifo_push, fifo_full, fifo_empty;
    logic [$clog2(FIFODEPTH):0] fifo_count;

`ifdef CPU_RUN_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           timed_out_q, timed_out_d;
    assign timedOut = timed_out_q;
`else
    assign timedOut = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        captured_d = captured_q;
        rcnt_d     = rcnt_q;
        fifo_flush = 1'b0;
        fifo_push  = 1'b0;
        cpu_reset  = 1'b0;
        cpu_enable = 1'b0;
`ifdef CPU_RUN_WATCHDOG_EN
        wd_d        = wd_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                cpu_reset = (state_q == IDLE);
                if (start) begin
                    state_d    = RESET_CPU;
                    count_d    = outCount;
                    captured_d = '0;
                    rcnt_d     = '0;
                    fifo_flush = 1'b1;
`ifdef CPU_RUN_WATCHDOG_EN
                    timed_out_d = 1'b0;
`endif
                end
            end
            RESET_CPU: begin
                cpu_reset  = 1'b1;
                cpu_enable = 1'b1;
                if (rcnt_q == RCW'(RESETCYCLES - 1)) begin
                    state_d = RUN;
`ifdef CPU_RUN_WATCHDOG_EN
                    wd_d = '0;
`endif
                end else begin
                    rcnt_d = rcnt_q + RCW'(1);
                end
            end
            RUN: begin
                // A stalled CPU keeps its flag up, so nothing is lost while full.
                cpu_enable = !fifo_full;
                if (cpu_enable && bus.cpuOutFlag) begin
                    fifo_push  = 1'b1;
                    captured_d = (&captured_q) ? captured_q : captured_q + COUNTWIDTH'(1);
                    if (count_q != '0 && captured_d == count_q) state_d = DRAIN;
`ifdef CPU_RUN_WATCHDOG_EN
                    wd_d = '0;
`endif
                end
`ifdef CPU_RUN_WATCHDOG_EN
                else if (cpu_enable) begin
                    if (wd_q == WDW'(TIMEOUT - 1)) begin
                        state_d     = DRAIN;
                        timed_out_d = 1'b1;
                    end else begin
                        wd_d = wd_q + WDW'(1);
                    end
                end
`endif
            end
            DRAIN: begin
                if (fifo_count == '0) state_d = DONE;
            end
            default: begin
                cpu_reset = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            captured_q <= '0;
            rcnt_q     <= '0;
`ifdef CPU_RUN_WATCHDOG_EN
            wd_q        <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            captured_q <= captured_d;
            rcnt_q     <= rcnt_d;
`ifdef CPU_RUN_WATCHDOG_EN
            wd_q        <= wd_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    run_out_fifo #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (FIFODEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (bus.cpuOut),
        .pop       (bus.outReady),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (bus.outData)
    );

    assign bus.cpuReset  = cpu_reset;
    assign bus.cpuEnable = cpu_enable;
    assign bus.outValid  = !fifo_empty;
    assign busy          = (state_q == RESET_CPU) || (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign captured      = captured_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
// Directed self-checking bench for cpu_run_controller (FIFODEPTH=4, RESETCYCLES=2, TIMEOUT=8).
`default_nettype none

module tb_cpu_run_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] outCount = '0;
    logic        busy, done, timedOut;
    logic [15:0] captured;

    int n_cmp = 0;
    int n_err = 0;

    logic [24:0] tx [16];
    logic [24:0] rx [$];

    cpu_run_controller_if #(.DATAWIDTH(25)) bus ();

    cpu_run_controller #(
        .DATAWIDTH(25), .FIFODEPTH(4), .COUNTWIDTH(16), .RESETCYCLES(2), .TIMEOUT(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .outCount(outCount),
        .bus(bus), .busy(busy), .done(done), .captured(captured), .timedOut(timedOut)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic do_start(input logic [15:0] cnt);
        start    = 1'b1;
        outCount = cnt;
        tick();
        start    = 1'b0;
    endtask

    // Models a CPU that holds each word until it is accepted, while logging pops.
    task automatic stream(input int first, input int n, input int budget);
        int  idx;
        int  cyc;
        bit  cap;
        idx = first;
        cyc = 0;
        bus.cpuOutFlag = (idx < n);
        if (idx < n) bus.cpuOut = tx[idx];
        while (!done && cyc < budget) begin
            cap = bus.cpuEnable && bus.cpuOutFlag;
            if (bus.outValid && bus.outReady) rx.push_back(bus.outData);
            tick();
            cyc++;
            if (cap) begin
                idx++;
                if (idx < n) bus.cpuOut = tx[idx];
                else bus.cpuOutFlag = 1'b0;
            end
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL stream_budget: done=%b after %0d cycles, required 1", done, cyc); end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (bus.cpuReset !== 1'b1) begin n_err++; $display("FAIL rst_cpuReset got=%b exp=1", bus.cpuReset); end
        n_cmp++; if (bus.cpuEnable !== 1'b0) begin n_err++; $display("FAIL rst_cpuEnable got=%b exp=0", bus.cpuEnable); end
        n_cmp++; if ({bus.outValid, done, busy, timedOut} !== 4'b0) begin n_err++; $display("FAIL rst_flags got=%b exp=0000", {bus.outValid, done, busy, timedOut}); end
        n_cmp++; if (captured !== 16'd0) begin n_err++; $display("FAIL rst_captured got=%0d exp=0", captured); end
        n_cmp++; if (bus.outData !== 25'd0) begin n_err++; $display("FAIL rst_outData got=%h exp=0", bus.outData); end
        @(negedge clock);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset_window();
        bus.cpuOutFlag = 1'b0;
        do_start(16'd0);
        n_cmp++; if ({bus.cpuReset, busy} !== 2'b11) begin n_err++; $display("FAIL win_k0 cpuReset,busy got=%b exp=11", {bus.cpuReset, busy}); end
        tick();
        n_cmp++; if (bus.cpuReset !== 1'b1) begin n_err++; $display("FAIL win_k1 cpuReset got=%b exp=1", bus.cpuReset); end
        tick();
        n_cmp++; if ({bus.cpuReset, bus.cpuEnable} !== 2'b01) begin n_err++; $display("FAIL win_k2 cpuReset,cpuEnable got=%b exp=01", {bus.cpuReset, bus.cpuEnable}); end
        do_start(16'd0);
        tick();
        n_cmp++; if ({bus.cpuReset, bus.cpuEnable, busy} !== 3'b011) begin n_err++; $display("FAIL win_restart got=%b exp=011", {bus.cpuReset, bus.cpuEnable, busy}); end
        pulse_reset();
    endtask

    task automatic test_basic();
        bus.outReady = 1'b1;
        do_start(16'd3);
        tick(); tick();
        bus.cpuOutFlag = 1'b1; bus.cpuOut = 25'h0000001;
        tick();
        n_cmp++; if ({bus.outValid, bus.outData} !== {1'b1, 25'h0000001}) begin n_err++; $display("FAIL basic_w0 got=%b/%h exp=1/0000001", bus.outValid, bus.outData); end
        n_cmp++; if (captured !== 16'd1) begin n_err++; $display("FAIL basic_cap1 got=%0d exp=1", captured); end
        bus.cpuOut = 25'h1ABCDEF;
        tick();
        n_cmp++; if (bus.outData !== 25'h1ABCDEF) begin n_err++; $display("FAIL basic_w1 got=%h exp=1abcdef", bus.outData); end
        bus.cpuOut = 25'h0000100;
        tick();
        bus.cpuOutFlag = 1'b0;
        n_cmp++; if (bus.outData !== 25'h0000100) begin n_err++; $display("FAIL basic_w2 got=%h exp=0000100", bus.outData); end
        n_cmp++; if ({captured, bus.cpuEnable} !== {16'd3, 1'b0}) begin n_err++; $display("FAIL basic_stop captured=%0d cpuEnable=%b exp 3/0", captured, bus.cpuEnable); end
        tick();
        n_cmp++; if ({bus.outValid, done} !== 2'b00) begin n_err++; $display("FAIL basic_lastpop outValid,done got=%b exp=00", {bus.outValid, done}); end
        tick();
        n_cmp++; if ({done, busy, bus.cpuReset} !== 3'b100) begin n_err++; $display("FAIL basic_done done,busy,cpuReset got=%b exp=100", {done, busy, bus.cpuReset}); end
    endtask

    task automatic test_backpressure();
        bus.outReady = 1'b0;
        rx.delete();
        do_start(16'd6);
        n_cmp++; if ({bus.cpuReset, done} !== 2'b10) begin n_err++; $display("FAIL bp_restart cpuReset,done got=%b exp=10", {bus.cpuReset, done}); end
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            bus.cpuOutFlag = 1'b1; bus.cpuOut = tx[i];
            tick();
        end
        n_cmp++; if ({bus.cpuEnable, captured} !== {1'b0, 16'd4}) begin n_err++; $display("FAIL bp_full cpuEnable=%b captured=%0d exp 0/4", bus.cpuEnable, captured); end
        bus.cpuOut = tx[4];
        tick(); tick();
        n_cmp++; if ({captured, bus.outData} !== {16'd4, tx[0]}) begin n_err++; $display("FAIL bp_stall captured=%0d head=%h exp 4/%h", captured, bus.outData, tx[0]); end
        bus.outReady = 1'b1;
        stream(4, 6, 60);
        n_cmp++; if (rx.size() !== 6) begin n_err++; $display("FAIL bp_count got=%0d exp=6", rx.size()); end
        for (int i = 0; i < 6 && i < rx.size(); i++) begin
            n_cmp++; if (rx[i] !== tx[i]) begin n_err++; $display("FAIL bp_word%0d got=%h exp=%h", i, rx[i], tx[i]); end
        end
        n_cmp++; if (captured !== 16'd6) begin n_err++; $display("FAIL bp_captured got=%0d exp=6", captured); end
    endtask

    task automatic test_pushpop_wrap();
        bus.outReady = 1'b0;
        rx.delete();
        do_start(16'd10);
        tick(); tick();
        bus.cpuOutFlag = 1'b1; bus.cpuOut = tx[0];
        tick();
        bus.cpuOut = tx[1];
        tick();
        n_cmp++; if (dut.fifo_count !== 3'd2) begin n_err++; $display("FAIL pp_occ_before got=%0d exp=2", dut.fifo_count); end
        bus.outReady = 1'b1; bus.cpuOut = tx[2];
        rx.push_back(bus.outData);
        tick();
        n_cmp++; if (dut.fifo_count !== 3'd2) begin n_err++; $display("FAIL pp_occ_after got=%0d exp=2", dut.fifo_count); end
        n_cmp++; if (bus.outData !== tx[1]) begin n_err++; $display("FAIL pp_head got=%h exp=%h", bus.outData, tx[1]); end
        stream(3, 10, 60);
        n_cmp++; if (rx.size() !== 10) begin n_err++; $display("FAIL wrap_count got=%0d exp=10", rx.size()); end
        for (int i = 0; i < 10 && i < rx.size(); i++) begin
            n_cmp++; if (rx[i] !== tx[i]) begin n_err++; $display("FAIL wrap_word%0d got=%h exp=%h", i, rx[i], tx[i]); end
        end
    endtask

    task automatic test_reset_midrun();
        bus.outReady = 1'b0;
        do_start(16'd0);
        tick(); tick();
        bus.cpuOutFlag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.cpuOut = tx[i];
            tick();
        end
        bus.cpuOutFlag = 1'b0;
        n_cmp++; if ({bus.outValid, captured} !== {1'b1, 16'd3}) begin n_err++; $display("FAIL mid_pre outValid=%b captured=%0d exp 1/3", bus.outValid, captured); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({bus.cpuReset, bus.outValid, busy, captured} !== {3'b100, 16'd0}) begin n_err++; $display("FAIL mid_abort cpuReset=%b outValid=%b busy=%b captured=%0d exp 1/0/0/0", bus.cpuReset, bus.outValid, busy, captured); end
        #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_watchdog();
        bus.outReady = 1'b1;
        bus.cpuOutFlag = 1'b0;
        do_start(16'd0);
        tick(); tick();
        for (int i = 0; i < 7; i++) tick();
        n_cmp++; if (bus.cpuEnable !== 1'b1) begin n_err++; $display("FAIL wd_7 cpuEnable got=%b exp=1", bus.cpuEnable); end
        tick();
`ifdef CPU_RUN_WATCHDOG_EN
        n_cmp++; if ({bus.cpuEnable, timedOut, busy} !== 3'b011) begin n_err++; $display("FAIL wd_8 cpuEnable,timedOut,busy got=%b exp=011", {bus.cpuEnable, timedOut, busy}); end
        tick();
        n_cmp++; if ({done, timedOut} !== 2'b11) begin n_err++; $display("FAIL wd_done done,timedOut got=%b exp=11", {done, timedOut}); end
`else
        n_cmp++; if ({bus.cpuEnable, timedOut, busy} !== 3'b101) begin n_err++; $display("FAIL wd_8 cpuEnable,timedOut,busy got=%b exp=101", {bus.cpuEnable, timedOut, busy}); end
        for (int i = 0; i < 20; i++) tick();
        n_cmp++; if ({bus.cpuEnable, timedOut, done} !== 3'b100) begin n_err++; $display("FAIL wd_stay cpuEnable,timedOut,done got=%b exp=100", {bus.cpuEnable, timedOut, done}); end
`endif
        pulse_reset();
    endtask

    initial begin
        bus.cpuOutFlag = 1'b0;
        bus.cpuOut     = '0;
        bus.outReady   = 1'b0;
        for (int i = 0; i < 16; i++) tx[i] = 25'((i + 1) * 32'h00B4F3D1);
        test_reset();
        test_reset_window();
        test_basic();
        test_backpressure();
        test_pushpop_wrap();
        test_reset_midrun();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_run_controller.md
# cpu_run_controller

Sequences one CPU test run and buffers the CPU's flagged 25-bit output words for a downstream consumer. Holds the CPU in reset until `start`, releases it after a fixed reset window and clocks it only while the output buffer has room. Captures each word presented with `outFlag`, stops the CPU after a programmed number of words, then drains the buffer. Sits between the CPU's `outFlag`/`out` port and the host-side result sink, replacing ad-hoc bench sequencing.

## Interface
- `DATAWIDTH`, 25: CPU output word width.
- `FIFODEPTH`, 4: buffer entries; power of two, ≥2.
- `COUNTWIDTH`, 16: width of word counters.
- `RESETCYCLES`, 2: cycles `cpuReset` is held after `start`; ≥1.
- `TIMEOUT`, 1024: watchdog limit in enabled RUN cycles; used only with the macro.
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  begin run; honoured only in IDLE or DONE.
- `outCount`  in  COUNTWIDTH  words to capture; 0 means unbounded. Sampled at `start`.
- `cpuOutFlag`  in  1  CPU output-valid.
- `cpuOut`  in  DATAWIDTH  CPU output word.
- `cpuReset`  out  1  active-high reset to CPU.
- `cpuEnable`  out  1  CPU clock enable.
- `outValid`  out  1  buffer head valid.
- `outData`  out  DATAWIDTH  buffer head word.
- `outReady`  in  1  consumer accepts head.
- `busy`  out  1  state is RESET_CPU, RUN or DRAIN.
- `done`  out  1  state is DONE.
- `captured`  out  COUNTWIDTH  words captured this run.
- `timedOut`  out  1  sticky watchdog flag. Constant 0 without the macro.

## Operation
- States:
  - IDLE: `cpuReset`=1, `cpuEnable`=0.
  - RESET_CPU: `cpuReset`=1, `cpuEnable`=1.
  - RUN: `cpuReset`=0, `cpuEnable`=!full.
  - DRAIN: `cpuReset`=0, `cpuEnable`=0.
  - DONE: `cpuReset`=0, `cpuEnable`=0; CPU state is held for inspection.
- IDLE/DONE + `start` → RESET_CPU:
  - latch `outCount`;
  - clear `captured`, `timedOut` and the reset counter;
  - flush the buffer.
- RESET_CPU → RUN after exactly RESETCYCLES cycles in RESET_CPU.
- Capture happens when RUN && `cpuEnable` && `cpuOutFlag`:
  - push `cpuOut`;
  - `captured`+1, saturating at all-ones.
- A flag raised while full is not captured. The CPU is stalled, so it re-presents the flag once enabled.
- RUN → DRAIN on the cycle the capture makes `captured` equal the latched nonzero count.
- DRAIN → DONE when the buffer is empty.
- Buffer:
  - pop when `outValid`&&`outReady`;
  - simultaneous push and pop on a non-empty buffer leaves occupancy unchanged;
  - `outData` is stable while `outValid`&&!`outReady`;
  - pointers wrap modulo FIFODEPTH.
- `start` outside IDLE/DONE is ignored.

## Timing
- Reset values:
  - state IDLE;
  - `cpuReset`=1 and `cpuEnable`=0;
  - `outValid`, `done`, `busy` and `timedOut` = 0;
  - `captured`=0;
  - `outData`=0.
- Reset asserted mid-run aborts at once and discards buffered words.
- `start` at edge k → RESET_CPU from k. `cpuReset` falls after edge k+RESETCYCLES.
- Capture at edge k → `outValid` earliest after edge k (registered, no bypass). `captured` updates at edge k.
- `cpuEnable` is combinational from the full flag; it drops in the same cycle occupancy reaches FIFODEPTH.
- `done` rises one cycle after the last pop.

## Configuration
- Macro `CPU_RUN_WATCHDOG_EN`.
- Defined: a watchdog counter is cleared on RUN entry and on each capture, and increments on RUN cycles with `cpuEnable`=1. When it reaches TIMEOUT: RUN → DRAIN and `timedOut`=1, sticky until the next `start`.
- Undefined: no counter is built, `timedOut` is tied 0, and RUN exits only on count match.

## Structure
- Package `cpu_run_pkg`:
  - state enum `run_state_t` (IDLE, RESET_CPU, RUN, DRAIN, DONE);
  - default width constants.
- Sub-module `run_out_fifo`: synchronous FIFO with push/pop, full/empty flags, occupancy, a flush input and asynchronous active-low reset. The controller keeps only the FSM and the counters.

## Test plan
- `outCount`=3, `outReady`=1, CPU flags words 0x0000001, 0x1ABCDEF, 0x0000100 → `outData` returns them in order, `captured`=3, `done`=1, `cpuEnable`=0 after the third.
- `outReady`=0, FIFODEPTH=4, `outCount`=6 → `cpuEnable` drops after the fourth capture. Raising `outReady` delivers all 6 in order with no loss or duplicates.
- RESETCYCLES=2, `start` pulse → `cpuReset` high for exactly 2 cycles after `start`, then low. A second `start` during RUN has no effect.
- Simultaneous push and pop at occupancy 2 → occupancy stays 2; pointer wrap over 10 words leaves data intact.
- Reset asserted during RUN with 3 buffered words → state IDLE, `outValid`=0, `captured`=0, `cpuReset`=1 immediately.
- With the macro and TIMEOUT=8, CPU silent → DRAIN after 8 enabled cycles, `timedOut`=1, then DONE. Without the macro the same stimulus stays in RUN.
